// File: rtl/avmm_fifo_mailbox.sv
// avmm_fifo_mailbox: NCH-channel Avalon-MM TX/RX FIFO mailbox with flush, sticky errors, optional irq.
// Optional interrupt logic is built in when AVMM_FIFO_MBOX_IRQ_EN is defined.
module avmm_fifo_mailbox #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int NCH    = 2,
  parameter int ADDR_W = 6
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    avs_waitrequest,
  output logic [NCH*DATA_W-1:0]   tx_data,
  output logic [NCH-1:0]          tx_empty,
  input  logic [NCH-1:0]          tx_rd,
  input  logic [NCH*DATA_W-1:0]   rx_data,
  input  logic [NCH-1:0]          rx_wr,
  output logic [NCH-1:0]          rx_full,
  output logic                    irq
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = ADDR_W - 2;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t r_state, w_next;
  logic w_rd_go;
  logic [31:0] r_readdata, w_rdata;
  logic [CW-1:0] w_ch;
  logic [1:0] w_reg;
  logic [31:0] w_status [NCH];
  logic [31:0] w_rx_word [NCH];
  logic [2:0] w_err [NCH];
  logic [NCH-1:0] w_ien, w_pend;
  assign w_ch = avs_address[ADDR_W-1:2];
  assign w_reg = avs_address[1:0];
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb w_next = (r_state == IDLE && avs_read) ? RD_WAIT : IDLE;
  always_comb begin
    w_rd_go = r_state == IDLE && avs_read;
    avs_waitrequest = w_rd_go && !reset_reset;
  end
  // Channels >= NCH never match, so their reads fall through to zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (w_ch == CW'(i))
        w_rdata = w_reg == 2'd0 ? w_rx_word[i] :
                  w_reg == 2'd1 ? w_status[i] :
                  w_reg == 2'd2 ? {29'b0, w_ien[i], 2'b0} : {29'b0, w_err[i]};
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_readdata <= '0;
    else if (w_rd_go) r_readdata <= w_rdata;
  end
  assign avs_readdata = r_readdata;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [LW-1:0] r_tx_lvl, r_rx_lvl;
    logic [2:0] r_err, w_err_set, w_err_clr;
    logic w_sel, w_dw, w_dr, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_fl, w_rx_fl;
    assign w_sel = w_ch == CW'(c);
    assign w_dw = w_sel && avs_write && w_reg == 2'd0;
    assign w_dr = w_sel && w_rd_go && w_reg == 2'd0;
    assign w_tx_full = r_tx_lvl == LW'(DEPTH);
    assign w_tx_empty = r_tx_lvl == '0;
    assign w_rx_full = r_rx_lvl == LW'(DEPTH);
    assign w_rx_empty = r_rx_lvl == '0;
    assign w_tx_fl = w_sel && avs_write && w_reg == 2'd2 && avs_writedata[0];
    assign w_rx_fl = w_sel && avs_write && w_reg == 2'd2 && avs_writedata[1];
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign w_tx_pop = tx_rd[c] && !w_tx_empty;
    assign w_tx_push = w_dw && (!w_tx_full || w_tx_pop);
    assign w_rx_pop = w_dr && !w_rx_empty;
    assign w_rx_push = rx_wr[c] && (!w_rx_full || w_rx_pop);
    assign w_err_set = {rx_wr[c] && w_rx_full && !w_rx_pop && !w_rx_fl,
                        w_dr && w_rx_empty,
                        w_dw && w_tx_full && !w_tx_pop};
    assign w_err_clr = (w_sel && avs_write && w_reg == 2'd3) ? avs_writedata[2:0] : 3'b0;
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        r_tx_wp <= '0;
        r_tx_rp <= '0;
        r_tx_lvl <= '0;
        r_rx_wp <= '0;
        r_rx_rp <= '0;
        r_rx_lvl <= '0;
        r_err <= '0;
      end else begin
        r_tx_wp <= w_tx_fl ? '0 : r_tx_wp + PW'(w_tx_push);
        r_tx_rp <= w_tx_fl ? '0 : r_tx_rp + PW'(w_tx_pop);
        r_tx_lvl <= w_tx_fl ? '0 : r_tx_lvl + LW'(w_tx_push) - LW'(w_tx_pop);
        r_rx_wp <= w_rx_fl ? '0 : r_rx_wp + PW'(w_rx_push);
        r_rx_rp <= w_rx_fl ? '0 : r_rx_rp + PW'(w_rx_pop);
        r_rx_lvl <= w_rx_fl ? '0 : r_rx_lvl + LW'(w_rx_push) - LW'(w_rx_pop);
        r_err <= (r_err & ~w_err_clr) | w_err_set;
      end
    end
    always_ff @(posedge clk_clk) begin
      if (w_tx_push && !w_tx_fl) r_tx_mem[r_tx_wp] <= avs_writedata[DATA_W-1:0];
      if (w_rx_push && !w_rx_fl) r_rx_mem[r_rx_wp] <= rx_data[c*DATA_W +: DATA_W];
    end
`ifdef AVMM_FIFO_MBOX_IRQ_EN
    logic r_ien;
    always_ff @(posedge clk_clk) begin
      if (reset_reset) r_ien <= 1'b0;
      else if (w_sel && avs_write && w_reg == 2'd2) r_ien <= avs_writedata[2];
    end
    assign w_ien[c] = r_ien;
`else
    assign w_ien[c] = 1'b0;
`endif
    assign w_pend[c] = w_ien[c] && !w_rx_empty;
    assign w_err[c] = r_err;
    assign w_status[c] = {w_pend[c], w_tx_full, w_rx_empty, 13'(r_tx_lvl), 16'(r_rx_lvl)};
    assign w_rx_word[c] = w_rx_empty ? '0 : 32'(r_rx_mem[r_rx_rp]);
    assign tx_data[c*DATA_W +: DATA_W] = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
    assign tx_empty[c] = w_tx_empty;
    assign rx_full[c] = w_rx_full;
  end
`ifdef AVMM_FIFO_MBOX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_irq <= 1'b0;
    else r_irq <= |w_pend;
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_avmm_fifo_mailbox.sv
// tb_avmm_fifo_mailbox: directed self-checking bench for avmm_fifo_mailbox (NCH=2, DEPTH=16, DATA_W=32).
module tb_avmm_fifo_mailbox;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic [5:0] avs_address = '0;
  logic avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic avs_waitrequest;
  logic [63:0] tx_data;
  logic [1:0] tx_empty;
  logic [1:0] tx_rd = '0;
  logic [63:0] rx_data = '0;
  logic [1:0] rx_wr = '0;
  logic [1:0] rx_full;
  logic irq;
  int checks = 0, errors = 0;
  logic [31:0] d;
  int n;
  always #5 clk_clk = ~clk_clk;
  avmm_fifo_mailbox #(.DATA_W(32), .DEPTH(16), .NCH(2), .ADDR_W(6)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd(tx_rd),
    .rx_data(rx_data), .rx_wr(rx_wr), .rx_full(rx_full), .irq(irq));
  task automatic wr(input logic [5:0] a, input logic [31:0] v);
    @(negedge clk_clk);
    avs_address = a;
    avs_writedata = v;
    avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask
  task automatic rd(input logic [5:0] a, output logic [31:0] v, output int cyc);
    @(negedge clk_clk);
    avs_address = a;
    avs_read = 1'b1;
    #1;
    cyc = 1;
    while (avs_waitrequest && cyc < 10) begin
      @(negedge clk_clk);
      cyc++;
    end
    v = avs_readdata;
    avs_read = 1'b0;
  endtask
  task automatic rx_push(input int ch, input logic [31:0] v);
    @(negedge clk_clk);
    rx_data[ch*32 +: 32] = v;
    rx_wr[ch] = 1'b1;
    @(negedge clk_clk);
    rx_wr = '0;
  endtask
  task automatic tx_pop(input int ch);
    @(negedge clk_clk);
    tx_rd[ch] = 1'b1;
    @(negedge clk_clk);
    tx_rd = '0;
  endtask
  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    checks++; if (tx_empty !== 2'b11) begin errors++; $display("FAIL rst_tx_empty got %b exp 11", tx_empty); end
    checks++; if (rx_full !== 2'b00) begin errors++; $display("FAIL rst_rx_full got %b exp 00", rx_full); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL rst_tx_data got %h exp 0", tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq got %b exp 0", avs_waitrequest); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got %h exp 0", avs_readdata); end
    reset_reset = 1'b0;
    rd(6'd1, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL rst_status0 got %h exp 20000000", d); end
    checks++; if (n !== 2) begin errors++; $display("FAIL rst_read_cycles got %0d exp 2", n); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL rst_status1 got %h exp 20000000", d); end
    wr(6'd8, 32'h1234);
    rd(6'd9, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL badch_read got %h exp 0", d); end
    checks++; if (tx_empty !== 2'b11) begin errors++; $display("FAIL badch_write got %b exp 11", tx_empty); end
  endtask
  task automatic test_tx();
    for (int i = 0; i < 16; i++) wr(6'd4, 32'hA5A5_0001 + i);
    checks++; if (tx_empty !== 2'b01) begin errors++; $display("FAIL tx_empty_filled got %b exp 01", tx_empty); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h6010_0000) begin errors++; $display("FAIL tx_status_full got %h exp 60100000", d); end
    rd(6'd7, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_err_pre got %h exp 0", d); end
    wr(6'd4, 32'hDEAD_BEEF);
    rd(6'd7, d, n);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL tx_ovf got %h exp 1", d); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h6010_0000) begin errors++; $display("FAIL tx_status_ovf got %h exp 60100000", d); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (tx_data[63:32] !== 32'hA5A5_0001 + i || tx_empty[1] !== 1'b0) begin errors++; $display("FAIL tx_pop_%0d got %h/%b exp %h/0", i, tx_data[63:32], tx_empty[1], 32'hA5A5_0001 + i); end
      tx_pop(1);
    end
    checks++; if (tx_empty !== 2'b11 || tx_data !== 64'h0) begin errors++; $display("FAIL tx_drained got %b/%h exp 11/0", tx_empty, tx_data); end
    wr(6'd7, 32'h1);
    tx_pop(1);
    rd(6'd7, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_empty_pop_flag got %h exp 0", d); end
  endtask
  task automatic test_rx();
    rx_push(0, 32'h11);
    rx_push(0, 32'h22);
    rx_push(0, 32'h33);
    rd(6'd1, d, n);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL rx_status3 got %h exp 3", d); end
    for (int i = 0; i < 3; i++) begin
      rd(6'd0, d, n);
      checks++; if (d !== 32'h11 * (i + 1) || n !== 2) begin errors++; $display("FAIL rx_read_%0d got %h/%0d exp %h/2", i, d, n, 32'h11 * (i + 1)); end
    end
    rd(6'd0, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_udf_data got %h exp 0", d); end
    rd(6'd3, d, n);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rx_udf_flag got %h exp 2", d); end
    wr(6'd3, 32'h2);
    rd(6'd3, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_udf_clear got %h exp 0", d); end
    rd(6'd1, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL rx_udf_status got %h exp 20000000", d); end
  endtask
  task automatic test_simul();
    for (int i = 0; i < 16; i++) rx_push(0, 32'h100 + i);
    checks++; if (rx_full !== 2'b01) begin errors++; $display("FAIL sim_rx_full got %b exp 01", rx_full); end
    @(negedge clk_clk);
    avs_address = 6'd0;
    avs_read = 1'b1;
    rx_data[31:0] = 32'h999;
    rx_wr[0] = 1'b1;
    @(negedge clk_clk);
    rx_wr = '0;
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h100) begin errors++; $display("FAIL sim_pop_push got %b/%h exp 0/100", avs_waitrequest, avs_readdata); end
    avs_read = 1'b0;
    rd(6'd1, d, n);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL sim_level got %h exp 10", d); end
    rd(6'd3, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sim_no_ovf got %h exp 0", d); end
    rx_push(0, 32'hAAA);
    rd(6'd3, d, n);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL sim_rx_ovf got %h exp 4", d); end
    @(negedge clk_clk);
    avs_address = 6'd3;
    avs_writedata = 32'h4;
    avs_write = 1'b1;
    rx_wr[0] = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
    rx_wr = '0;
    rd(6'd3, d, n);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL sim_set_wins got %h exp 4", d); end
    wr(6'd3, 32'h4);
    @(negedge clk_clk);
    avs_address = 6'd2;
    avs_writedata = 32'h2;
    avs_write = 1'b1;
    rx_wr[0] = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
    rx_wr = '0;
    rd(6'd1, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL sim_flush_push got %h exp 20000000", d); end
    rd(6'd3, d, n);
    checks++; if (d !== 32'h0 || rx_full !== 2'b00) begin errors++; $display("FAIL sim_flush_err got %h/%b exp 0/00", d, rx_full); end
    wr(6'd0, 32'h1);
    wr(6'd0, 32'h2);
    checks++; if (tx_empty !== 2'b10 || tx_data[31:0] !== 32'h1) begin errors++; $display("FAIL tx_head got %b/%h exp 10/1", tx_empty, tx_data[31:0]); end
    wr(6'd2, 32'h1);
    checks++; if (tx_empty !== 2'b11 || tx_data !== 64'h0) begin errors++; $display("FAIL tx_flush got %b/%h exp 11/0", tx_empty, tx_data); end
    rd(6'd2, d, n);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_selfclear got %h exp 0", d); end
  endtask
  task automatic test_back_to_back();
    rx_push(0, 32'h71);
    rx_push(0, 32'h72);
    @(negedge clk_clk);
    avs_address = 6'd0;
    avs_read = 1'b1;
    #1;
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_wait0 got %b exp 1", avs_waitrequest); end
    @(negedge clk_clk);
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h71) begin errors++; $display("FAIL b2b_word0 got %b/%h exp 0/71", avs_waitrequest, avs_readdata); end
    @(negedge clk_clk);
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_wait1 got %b exp 1", avs_waitrequest); end
    @(negedge clk_clk);
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h72) begin errors++; $display("FAIL b2b_word1 got %b/%h exp 0/72", avs_waitrequest, avs_readdata); end
    avs_read = 1'b0;
    rd(6'd1, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL b2b_status got %h exp 20000000", d); end
  endtask
  task automatic test_irq();
    wr(6'd6, 32'h4);
    rd(6'd6, d, n);
`ifdef AVMM_FIFO_MBOX_IRQ_EN
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL irq_ctrl got %h exp 4", d); end
    rx_push(1, 32'h5A);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    @(negedge clk_clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL irq_status got %h exp 80000001", d); end
    rd(6'd4, d, n);
    checks++; if (d !== 32'h5A || irq !== 1'b1) begin errors++; $display("FAIL irq_pop got %h/%b exp 5a/1", d, irq); end
    @(negedge clk_clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
    wr(6'd6, 32'h0);
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_ctrl got %h exp 0", d); end
    rx_push(1, 32'h5A);
    @(negedge clk_clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL irq_status got %h exp 1", d); end
    rd(6'd4, d, n);
    checks++; if (d !== 32'h5A || irq !== 1'b0) begin errors++; $display("FAIL irq_pop got %h/%b exp 5a/0", d, irq); end
`endif
  endtask
  task automatic test_reset_mid_read();
    rx_push(0, 32'h55);
    rx_push(0, 32'h66);
    wr(6'd4, 32'h77);
    @(negedge clk_clk);
    avs_address = 6'd0;
    avs_read = 1'b1;
    @(negedge clk_clk);
    checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_rdwait got %b exp 0", avs_waitrequest); end
    reset_reset = 1'b1;
    avs_read = 1'b0;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h0) begin errors++; $display("FAIL mid_idle got %b/%h exp 0/0", avs_waitrequest, avs_readdata); end
    checks++; if (tx_empty !== 2'b11 || rx_full !== 2'b00) begin errors++; $display("FAIL mid_flags got %b/%b exp 11/00", tx_empty, rx_full); end
    rd(6'd1, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL mid_status0 got %h exp 20000000", d); end
    rd(6'd5, d, n);
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL mid_status1 got %h exp 20000000", d); end
  endtask
  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_simul();
    test_back_to_back();
    test_irq();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
